// File: rtl/alu_mdu_issue_decoder_if.sv
// ID -> decoder -> EX handshake bundle for the ALU/MDU issue decoder.
// The ALU function codes live here so both the interface and the decoder see them.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define ALU_FUNCT_ADD  4'd0
`define ALU_FUNCT_SUB  4'd1
`define ALU_FUNCT_SLL  4'd2
`define ALU_FUNCT_SLT  4'd3
`define ALU_FUNCT_SLTU 4'd4
`define ALU_FUNCT_XOR  4'd5
`define ALU_FUNCT_SRL  4'd6
`define ALU_FUNCT_SRA  4'd7
`define ALU_FUNCT_OR   4'd8
`define ALU_FUNCT_AND  4'd9
`endif

interface alu_mdu_issue_decoder_if;
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  funct3;
  logic [6:0]                  funct7;
  logic                        is_imm;
  logic                        controlOverride;
  logic                        out_valid;
  logic                        out_ready;
  logic [`ALU_FUNCT_WIDTH-1:0] alu_funct;
  logic [2:0]                  mdu_funct;
  logic                        use_mdu;
  logic                        illegal;
  logic                        mdu_busy;

  // ID/EX side
  modport master (
    output in_valid, funct3, funct7, is_imm, controlOverride, out_ready,
    input  in_ready, out_valid, alu_funct, mdu_funct, use_mdu, illegal, mdu_busy
  );

  // decoder side
  modport slave (
    input  in_valid, funct3, funct7, is_imm, controlOverride, out_ready,
    output in_ready, out_valid, alu_funct, mdu_funct, use_mdu, illegal, mdu_busy
  );
endinterface

// File: rtl/alu_mdu_issue_decoder.sv
// Registered ALU / RV32M decoder between ID and EX. One-entry output stage;
// MDU ops are held while the iterative mul/div unit is still occupied.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define ALU_FUNCT_ADD  4'd0
`define ALU_FUNCT_SUB  4'd1
`define ALU_FUNCT_SLL  4'd2
`define ALU_FUNCT_SLT  4'd3
`define ALU_FUNCT_SLTU 4'd4
`define ALU_FUNCT_XOR  4'd5
`define ALU_FUNCT_SRL  4'd6
`define ALU_FUNCT_SRA  4'd7
`define ALU_FUNCT_OR   4'd8
`define ALU_FUNCT_AND  4'd9
`endif

module alu_mdu_issue_decoder #(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_mdu_issue_decoder_if.slave     bus
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  typedef struct packed {
    logic [`ALU_FUNCT_WIDTH-1:0] alu_funct;
    logic [2:0]                  mdu_funct;
    logic                        use_mdu;
    logic                        illegal;
  } op_t;

  localparam op_t OP_RST = '{alu_funct: `ALU_FUNCT_ADD, mdu_funct: 3'd0,
                             use_mdu: 1'b0, illegal: 1'b0};

  op_t           op_q, op_d, dec;
  logic          full_q, full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, out_valid, handoff, in_ready, accept;

  assign busy      = (cnt_q != '0);
  assign out_valid = full_q && !(op_q.use_mdu && busy);
  assign handoff   = out_valid && bus.out_ready;
  assign in_ready  = !full_q || handoff;
  assign accept    = bus.in_valid && in_ready;

  // Decode the presented instruction; every path starts from a clean ADD
  // so nothing stale leaks from a previous op.
  always_comb begin
    dec = OP_RST;
    if (bus.controlOverride) begin
      dec = OP_RST;
    end else if (!bus.is_imm && (ENABLE_M != 0) && bus.funct7 == F7_MDU) begin
      dec.use_mdu   = 1'b1;
      dec.mdu_funct = bus.funct3;
    end else begin
      unique case (bus.funct3)
        3'b000: begin
          // ADDI carries a sign-extended immediate in funct7; never SUB.
          if (bus.is_imm || bus.funct7 == F7_BASE) dec.alu_funct = `ALU_FUNCT_ADD;
          else if (bus.funct7 == F7_ALT)          dec.alu_funct = `ALU_FUNCT_SUB;
          else                                    dec.illegal   = 1'b1;
        end
        3'b101: begin
          if (bus.funct7 == F7_BASE)     dec.alu_funct = `ALU_FUNCT_SRL;
          else if (bus.funct7 == F7_ALT) dec.alu_funct = `ALU_FUNCT_SRA;
          else                           dec.illegal   = 1'b1;
        end
        3'b001: begin
          if (bus.funct7 == F7_BASE) dec.alu_funct = `ALU_FUNCT_SLL;
          else                       dec.illegal   = 1'b1;
        end
        default: begin
          if (bus.is_imm || bus.funct7 == F7_BASE) begin
            unique case (bus.funct3)
              3'b010:  dec.alu_funct = `ALU_FUNCT_SLT;
              3'b011:  dec.alu_funct = `ALU_FUNCT_SLTU;
              3'b100:  dec.alu_funct = `ALU_FUNCT_XOR;
              3'b110:  dec.alu_funct = `ALU_FUNCT_OR;
              default: dec.alu_funct = `ALU_FUNCT_AND;
            endcase
          end else begin
            dec.illegal = 1'b1;
          end
        end
      endcase
    end
  end

  // Stage occupancy, held op and MDU occupancy counter next-state.
  always_comb begin
    full_d = full_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    if (handoff) full_d = 1'b0;
    if (accept) begin
      full_d = 1'b1;
      op_d   = dec;
    end
    if (handoff && op_q.use_mdu) cnt_d = op_q.mdu_funct[2] ? DIV_LD : MUL_LD;
    else if (busy)               cnt_d = cnt_q - CW'(1);
  end

  // State registers; reset drops any held op and clears MDU occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      op_q   <= OP_RST;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_funct = op_q.alu_funct;
  assign bus.mdu_funct = op_q.mdu_funct;
  assign bus.use_mdu   = op_q.use_mdu;
  assign bus.illegal   = op_q.illegal;
  assign bus.mdu_busy  = busy;

endmodule
